neopix_frame_ctrl: RTL and testbench

//  Double-buffered pixel frame controller between the SPI byte receiver and the ws2812 serial driver.
//  The SPI side fills a back bank with R,G,B bytes and commits the frame.
//  The block swaps banks only while the driver is in its reset/latch gap, so a frame is never torn.
//  It answers the driver's data_request/address with that LED's colour from the front bank.

---
 rtl/neopix_pkg.sv | 18 +
 rtl/neopix_frame_ctrl_if.sv | 21 ++
 rtl/neopix_pixel_ram.sv | 33 +++
 rtl/neopix_frame_ctrl.sv | 149 ++++++++++++++
 tb/tb_neopix_frame_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/neopix_pkg.sv
// rtl/neopix_pkg.sv - shared constants and helpers for the neopixel frame controller
package neopix_pkg;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    localparam logic [0:0] WS_FILL    = 1'b0;
    localparam logic [0:0] WS_PENDING = 1'b1;

    typedef logic [23:0] rgb_t;

    // The LED pointer must be able to hold NUM_LEDS itself (the "frame full" value).
    function automatic int led_ptr_w(input int num_leds);
        return $clog2(num_leds + 1);
    endfunction

endpackage

// File: rtl/neopix_frame_ctrl_if.sv
// rtl/neopix_frame_ctrl_if.sv - SPI-side pixel write bus with status back to the receiver
interface neopix_frame_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_sof;
    logic       wr_commit;
    logic       wr_ready;
    logic       wr_overflow;
    logic       commit_pending;
    logic       swap_done;

    modport master (
        output wr_valid, wr_data, wr_sof, wr_commit,
        input  wr_ready, wr_overflow, commit_pending, swap_done
    );

    modport slave (
        input  wr_valid, wr_data, wr_sof, wr_commit,
        output wr_ready, wr_overflow, commit_pending, swap_done
    );
endinterface

// File: rtl/neopix_pixel_ram.sv
// rtl/neopix_pixel_ram.sv - simple dual-port 24-bit pixel RAM, byte-enabled write, registered read
module neopix_pixel_ram #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [2:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [23:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [23:0]   o_rdata
);

    logic [23:0] r_mem [DEPTH];
    logic [23:0] r_rdata;

    // be[2] = red (msb byte), be[1] = green, be[0] = blue
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            if (i_be[2]) r_mem[i_waddr][23:16] <= i_wdata[23:16];
            if (i_be[1]) r_mem[i_waddr][15:8]  <= i_wdata[15:8];
            if (i_be[0]) r_mem[i_waddr][7:0]   <= i_wdata[7:0];
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/neopix_frame_ctrl.sv
// rtl/neopix_frame_ctrl.sv - double-buffered frame store between SPI receiver and ws2812 driver
module neopix_frame_ctrl
    import neopix_pkg::*;
#(
    parameter  int NUM_LEDS = 4,
    localparam int ADDR_W   = $clog2(NUM_LEDS)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    neopix_frame_ctrl_if.slave wr_if,
    input  logic              i_drv_reset_state,
    input  logic              i_drv_data_request,
    input  logic [ADDR_W-1:0] i_drv_address,
    output logic [7:0]        o_red_out,
    output logic [7:0]        o_green_out,
    output logic [7:0]        o_blue_out
);

    localparam int                 PTR_W   = led_ptr_w(NUM_LEDS);
    localparam logic [PTR_W-1:0]   LED_END = PTR_W'(NUM_LEDS);
    localparam int                 RAM_AW  = ADDR_W + 1;

    logic [0:0]       r_state;
    logic [PTR_W-1:0] r_led_ptr;
    logic [1:0]       r_col_ptr;
    logic             r_overflow;
    logic             r_front;
    logic             r_blank;
    logic             r_swap_done;
    logic             r_rd_zero;

    logic             w_fill;
    logic             w_accept;
    logic             w_sof;
    logic             w_commit;
    logic             w_swap;
    logic [PTR_W-1:0] w_led_cur;
    logic [1:0]       w_col_cur;
    logic             w_in_range;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_led_next;
    logic [1:0]       w_col_next;
    logic [PTR_W-1:0] w_led_upd;
    logic [1:0]       w_col_upd;
    logic [2:0]       w_be;
    logic             w_rd_zero;
    logic [RAM_AW-1:0] w_waddr;
    logic [RAM_AW-1:0] w_raddr;
    rgb_t             w_rdata;

    assign w_fill   = (r_state == WS_FILL);
    assign w_accept = wr_if.wr_valid  & w_fill;
    assign w_sof    = wr_if.wr_sof    & w_fill;
    assign w_commit = wr_if.wr_commit & w_fill;
    assign w_swap   = (r_state == WS_PENDING) & i_drv_reset_state & ~i_drv_data_request;

    // sof rewinds the pointer before a same-cycle byte is placed
    assign w_led_cur  = w_sof ? '0 : r_led_ptr;
    assign w_col_cur  = w_sof ? COL_R : r_col_ptr;
    assign w_in_range = (w_led_cur < LED_END);
    assign w_wr_en    = w_accept & w_in_range;

    assign w_col_next = (w_col_cur == COL_B) ? COL_R : (w_col_cur + 2'd1);
    assign w_led_next = (w_col_cur == COL_B) ? (w_led_cur + PTR_W'(1)) : w_led_cur;
    assign w_led_upd  = w_wr_en ? w_led_next : w_led_cur;
    assign w_col_upd  = w_wr_en ? w_col_next : w_col_cur;

    always_comb begin
        w_be = 3'b000;
        case (w_col_cur)
            COL_R:   w_be = 3'b100;
            COL_G:   w_be = 3'b010;
            COL_B:   w_be = 3'b001;
            default: w_be = 3'b000;
        endcase
    end

    assign w_waddr   = {~r_front, w_led_cur[ADDR_W-1:0]};
    assign w_raddr   = {r_front, i_drv_address};
    assign w_rd_zero = r_blank | (int'(i_drv_address) >= NUM_LEDS);

    // Address space is rounded up to a power of two so {bank, led} indexes directly.
    neopix_pixel_ram #(
        .DEPTH (2 ** RAM_AW),
        .AW    (RAM_AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_en),
        .i_be    (w_be),
        .i_waddr (w_waddr),
        .i_wdata ({3{wr_if.wr_data}}),
        .i_re    (i_drv_data_request),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= WS_FILL;
            r_led_ptr   <= '0;
            r_col_ptr   <= COL_R;
            r_overflow  <= 1'b0;
            r_front     <= 1'b0;
            r_blank     <= 1'b1;
            r_swap_done <= 1'b0;
            r_rd_zero   <= 1'b1;
        end else begin
            r_swap_done <= w_swap;
            if (i_drv_data_request) begin
                r_rd_zero <= w_rd_zero;
            end
            if (r_state == WS_FILL) begin
                if (w_sof || w_accept) begin
                    r_led_ptr <= w_led_upd;
                    r_col_ptr <= w_col_upd;
                end
                if (w_accept && !w_in_range) begin
                    r_overflow <= 1'b1;
                end else if (w_sof) begin
                    r_overflow <= 1'b0;
                end
                if (w_commit) begin
                    r_state <= WS_PENDING;
                end
            end else if (w_swap) begin
                r_state    <= WS_FILL;
                r_front    <= ~r_front;
                r_blank    <= 1'b0;
                r_led_ptr  <= '0;
                r_col_ptr  <= COL_R;
                r_overflow <= 1'b0;
            end
        end
    end

    // Reading the front bank while it flips would tear the frame.
    a_no_read_on_swap: assert property (@(posedge i_clk) disable iff (i_reset)
        !(w_swap && i_drv_data_request));

    assign wr_if.wr_ready       = w_fill;
    assign wr_if.wr_overflow    = r_overflow;
    assign wr_if.commit_pending = ~w_fill;
    assign wr_if.swap_done      = r_swap_done;

    assign o_red_out   = r_rd_zero ? 8'h00 : w_rdata[23:16];
    assign o_green_out = r_rd_zero ? 8'h00 : w_rdata[15:8];
    assign o_blue_out  = r_rd_zero ? 8'h00 : w_rdata[7:0];

endmodule

// File: tb/tb_neopix_frame_ctrl.sv
// tb/tb_neopix_frame_ctrl.sv - scoreboard bench for neopix_frame_ctrl against a frame-level model
module tb_neopix_frame_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       gap;
    logic       req;
    logic [1:0] addr;
    logic [7:0] red, green, blue;

    always #5 clk = ~clk;

    neopix_frame_ctrl_if wr_if ();

    neopix_frame_ctrl #(.NUM_LEDS(N)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .wr_if              (wr_if),
        .i_drv_reset_state  (gap),
        .i_drv_data_request (req),
        .i_drv_address      (addr),
        .o_red_out          (red),
        .o_green_out        (green),
        .o_blue_out         (blue)
    );

    typedef struct {
        bit          ready;
        bit          ovf;
        bit          pend;
        bit          swapd;
        logic [23:0] col;
        bit          col_known;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: two banks of LED colours, a byte counter into the frame, and which bank is shown.
    logic [23:0] m_bank  [2][N];
    bit          m_known [2][N][3];
    bit          m_front, m_blank, m_pending, m_ovf, m_swapd;
    int          m_cnt;
    logic [23:0] m_out;
    bit          m_out_known;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_ready",       32'(wr_if.wr_ready),       32'(e.ready));
            chk("wr_overflow",    32'(wr_if.wr_overflow),    32'(e.ovf));
            chk("commit_pending", 32'(wr_if.commit_pending), 32'(e.pend));
            chk("swap_done",      32'(wr_if.swap_done),      32'(e.swapd));
            if (e.col_known) chk("colour", 32'({red, green, blue}), 32'(e.col));
        end
    end

    task automatic model_edge(input bit v, input logic [7:0] d, input bit sof, input bit com,
                              input bit g, input bit rq, input logic [1:0] a, input bit rst);
        int led, b;
        if (rst) begin
            m_pending = 0; m_cnt = 0; m_ovf = 0; m_front = 0; m_blank = 1;
            m_out = '0; m_out_known = 1; m_swapd = 0;
            return;
        end
        if (rq) begin
            if (m_blank || int'(a) >= N) begin
                m_out = '0; m_out_known = 1;
            end else begin
                m_out = m_bank[m_front][a];
                m_out_known = m_known[m_front][a][0] & m_known[m_front][a][1] & m_known[m_front][a][2];
            end
        end
        m_swapd = 0;
        if (!m_pending) begin
            if (sof) begin m_cnt = 0; m_ovf = 0; end
            if (v) begin
                if (m_cnt < 3 * N) begin
                    led = m_cnt / 3;
                    b   = m_cnt % 3;
                    m_bank[!m_front][led][(2 - b) * 8 +: 8] = d;
                    m_known[!m_front][led][b] = 1;
                    m_cnt++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (com) m_pending = 1;
        end else if (g && !rq) begin
            m_front = !m_front; m_blank = 0; m_swapd = 1;
            m_pending = 0; m_cnt = 0; m_ovf = 0;
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit sof, input bit com,
                        input bit g, input bit rq, input logic [1:0] a, input bit rst);
        exp_t e;
        wr_if.wr_valid = v; wr_if.wr_data = d; wr_if.wr_sof = sof; wr_if.wr_commit = com;
        gap = g; req = rq; addr = a; reset = rst;
        model_edge(v, d, sof, com, g, rq, a, rst);
        e.ready = !m_pending; e.ovf = m_ovf; e.pend = m_pending; e.swapd = m_swapd;
        e.col = m_out; e.col_known = m_out_known;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic drv(input bit g, input bit rq, input logic [1:0] a);
        step(0, 8'h00, 0, 0, g, rq, a, 0);
    endtask

    task automatic wbyte(input logic [7:0] d, input bit sof);
        step(1, d, sof, 0, 0, 0, 2'd0, 0);
    endtask

    task automatic read_all();
        for (int i = 0; i < N; i++) begin
            drv(0, 1, 2'(i));
            drv(0, 0, 2'(i));
        end
    endtask

    task automatic commit_and_swap();
        step(0, 8'h00, 0, 1, 0, 0, 2'd0, 0);
        drv(1, 0, 2'd0);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < N; l++)
                for (int c = 0; c < 3; c++) m_known[b][l][c] = 0;
        wr_if.wr_valid = 0; wr_if.wr_data = 0; wr_if.wr_sof = 0; wr_if.wr_commit = 0;
        gap = 0; req = 0; addr = 0; reset = 1;
        @(posedge clk); #1;

        // reset, then a blank chain being scanned
        step(0, 8'h00, 0, 0, 0, 0, 2'd0, 1);
        step(0, 8'h00, 0, 0, 0, 0, 2'd0, 1);
        for (int i = 0; i < 20; i++) drv(i % 5 == 4, i % 5 != 4, 2'($urandom_range(0, 3)));

        // frame 01..0C, commit, swap in the gap, read back
        wbyte(8'h01, 1);
        for (int i = 2; i <= 12; i++) wbyte(8'(i), 0);
        step(0, 8'h00, 0, 1, 0, 0, 2'd0, 0);
        drv(0, 1, 2'd1);
        drv(0, 0, 2'd1);
        drv(1, 0, 2'd0);
        drv(0, 1, 2'd2); drv(0, 0, 2'd2);
        drv(0, 1, 2'd0); drv(0, 0, 2'd0);

        // writes while pending are dropped; next frame lands in the old front bank
        wbyte(8'h11, 1);
        for (int i = 1; i < 12; i++) wbyte(8'($urandom_range(0, 255)), 0);
        step(0, 8'h00, 0, 1, 0, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'hAA, i == 1, i == 2, 0, i[0], 2'(i), 0);
        drv(1, 0, 2'd0);
        read_all();

        // overflow after 12 bytes, cleared by the next sof
        wbyte(8'h21, 1);
        for (int i = 1; i < 14; i++) wbyte(8'(8'h21 + i), 0);
        drv(0, 0, 2'd0);
        step(0, 8'h00, 1, 0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 12; i++) wbyte(8'(8'h40 + i), 0);
        commit_and_swap();
        read_all();

        // commit mid-LED1; swap only once the gap arrives, and not on a request cycle
        wbyte(8'h51, 1); wbyte(8'h52, 0); wbyte(8'h53, 0);
        step(0, 8'h00, 0, 1, 0, 1, 2'd1, 0);
        for (int i = 0; i < 6; i++) drv(0, i % 3 == 0, 2'd1);
        drv(1, 1, 2'd2);
        drv(1, 0, 2'd0);
        read_all();

        // reset while pending
        wbyte(8'h61, 1); wbyte(8'h62, 0);
        step(0, 8'h00, 0, 1, 0, 0, 2'd0, 0);
        drv(0, 1, 2'd0);
        step(0, 8'h00, 0, 0, 0, 0, 2'd0, 1);
        drv(0, 1, 2'd0);
        drv(1, 0, 2'd0);
        read_all();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) < 2,
                 2'($urandom_range(0, 3)), $urandom_range(0, 199) == 0);
        end

        drv(0, 0, 2'd0);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
